// File: rtl/regfile_alu_pkg.sv
// Shared constants for the register-file execute/writeback controller:
// opcode encodings, FSM state encoding and default datapath/address widths.
package regfile_alu_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Two-operand ops occupy the low end of the opcode space.
  function automatic logic uses_src_b(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/regfile_alu_ctrl_alu8.sv
// Combinational ALU: result and carry/borrow from two operands, an immediate and an opcode.
// Zero latency; no handshake.
module alu8
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic [2:0]    op_code,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op_code)
      OP_ADD: {carry, result} = sum;
      // The extra top bit of the widened difference is the unsigned borrow.
      OP_SUB: {carry, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        carry  = a[DW-1];
      end
      OP_LDI: result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_ctrl.sv
// Execute/writeback controller: read regfile, ALU, write back; accept-to-WE latency 3 cycles.
// op_ready only in IDLE/WRITE (one op per 3 cycles back-to-back); op_valid is held off otherwise.
module regfile_alu_ctrl
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [AW-1:0] op_dst,
  input  logic [AW-1:0] op_srcA,
  input  logic [AW-1:0] op_srcB,
  input  logic [DW-1:0] op_imm,
  output logic [AW-1:0] Readaddress_A,
  output logic [AW-1:0] Readaddress_B,
  output logic          RE_A,
  output logic          RE_B,
  input  logic [DW-1:0] rf_dataA,
  input  logic [DW-1:0] rf_dataB,
  output logic [AW-1:0] Writeaddress,
  output logic          WE,
  output logic [DW-1:0] wr_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          done
);

  state_e        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_a_q, src_a_d;
  logic [AW-1:0] src_b_q, src_b_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] opnd_a_q, opnd_a_d;
  logic [DW-1:0] opnd_b_q, opnd_b_d;
  logic [DW-1:0] res_q, res_d;
  logic          carry_q, carry_d;
  logic          fz_q, fz_d;
  logic          fc_q, fc_d;

  logic          accept;
  logic          re_a;
  logic          re_b;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  alu8 #(.DW(DW)) u_alu (
    .a       (opnd_a_q),
    .b       (opnd_b_q),
    .imm     (imm_q),
    .op_code (code_q),
    .result  (alu_res),
    .carry   (alu_carry)
  );

  assign op_ready = ((state_q == ST_IDLE) || (state_q == ST_WRITE)) && !RST;
  assign accept   = op_valid && op_ready;
  assign re_a     = (state_q == ST_READ) && (code_q != OP_LDI);
  assign re_b     = (state_q == ST_READ) && uses_src_b(code_q);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    dst_d    = dst_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    imm_d    = imm_q;
    opnd_a_d = opnd_a_q;
    opnd_b_d = opnd_b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    fz_d     = fz_q;
    fc_d     = fc_q;

    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: begin
        state_d  = ST_EXEC;
        // Unread ports contribute zero so the ALU never sees stale regfile data.
        opnd_a_d = re_a ? rf_dataA : '0;
        opnd_b_d = re_b ? rf_dataB : '0;
      end
      ST_EXEC: begin
        state_d = ST_WRITE;
        res_d   = alu_res;
        carry_d = alu_carry;
      end
      ST_WRITE: begin
        state_d = accept ? ST_READ : ST_IDLE;
        fz_d    = (res_q == '0);
        fc_d    = carry_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      code_d  = op_code;
      dst_d   = op_dst;
      src_a_d = op_srcA;
      src_b_d = op_srcB;
      imm_d   = op_imm;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      dst_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_q    <= '0;
      opnd_a_q <= '0;
      opnd_b_q <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      dst_q    <= dst_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      imm_q    <= imm_d;
      opnd_a_q <= opnd_a_d;
      opnd_b_q <= opnd_b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
    end
  end

  // A reset arriving during WRITE must drop the pending commit in the same cycle.
  assign WE            = (state_q == ST_WRITE) && !RST;
  assign done          = (state_q == ST_WRITE) && !RST;
  assign RE_A          = re_a;
  assign RE_B          = re_b;
  assign Readaddress_A = src_a_q;
  assign Readaddress_B = src_b_q;
  assign Writeaddress  = dst_q;
  assign wr_data       = res_q;
  assign flag_z        = fz_q;
  assign flag_c        = fc_q;

endmodule

// File: tb/tb_regfile_alu_ctrl.sv
// Bench for regfile_alu_ctrl: attached 32x8 register file, directed vector table,
// hand-written multi-cycle sequences and random ops checked against an arithmetic model.
module tb_regfile_alu_ctrl;
  import regfile_alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [4:0] op_dst, op_srcA, op_srcB;
  logic [7:0] op_imm;
  logic [4:0] Readaddress_A, Readaddress_B, Writeaddress;
  logic       RE_A, RE_B, WE, done, flag_z, flag_c;
  logic [7:0] rf_dataA, rf_dataB, wr_data;

  always #5 CLK = ~CLK;

  regfile_alu_ctrl #(.DW(8), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_dst(op_dst), .op_srcA(op_srcA), .op_srcB(op_srcB),
    .op_imm(op_imm), .Readaddress_A(Readaddress_A), .Readaddress_B(Readaddress_B),
    .RE_A(RE_A), .RE_B(RE_B), .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .Writeaddress(Writeaddress), .WE(WE), .wr_data(wr_data),
    .flag_z(flag_z), .flag_c(flag_c), .done(done)
  );

  // Attached register file; disabled read ports return junk so operand gating is visible.
  logic [7:0] rf [32];
  logic       tb_clr;
  int         wr_cnt = 0;
  int         cyc = 0;

  always_comb begin
    rf_dataA = RE_A ? rf[Readaddress_A] : 8'hA5;
    rf_dataB = RE_B ? rf[Readaddress_B] : 8'h5A;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
    end else if (WE) begin
      rf[Writeaddress] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: expected register contents plus op semantics in plain arithmetic.
  logic [7:0] ref_rf [32];

  function automatic logic [9:0] model(input logic [2:0] code, input int a, input int b, input int imm);
    int r;
    int c;
    c = 0;
    case (code)
      3'd0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      3'd1: begin r = a - b; c = (a < b) ? 1 : 0; if (r < 0) r = r + 256; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: begin r = a * 2; c = (a >= 128) ? 1 : 0; end
      default: r = imm;
    endcase
    r = r % 256;
    model = {(r == 0), c[0], r[7:0]};
  endfunction

  task automatic drive_op(input logic [2:0] code, input logic [4:0] dst, input logic [4:0] sa,
                          input logic [4:0] sb, input logic [7:0] imm);
    op_valid = 1'b1;
    op_code  = code;
    op_dst   = dst;
    op_srcA  = sa;
    op_srcB  = sb;
    op_imm   = imm;
  endtask

  task automatic run_op(input string tag, input logic [2:0] code, input logic [4:0] dst,
                        input logic [4:0] sa, input logic [4:0] sb, input logic [7:0] imm,
                        input logic [7:0] exp_d, input logic exp_z, input logic exp_c);
    @(negedge CLK);
    chk({tag, " ready"}, op_ready, 1);
    drive_op(code, dst, sa, sb, imm);
    @(posedge CLK); #1 op_valid = 1'b0;
    @(negedge CLK);
    chk({tag, " read RE_A"}, RE_A, (code != OP_LDI));
    chk({tag, " read RE_B"}, RE_B, (code <= OP_XOR));
    if (code != OP_LDI) chk({tag, " read addrA"}, Readaddress_A, sa);
    if (code <= OP_XOR) chk({tag, " read addrB"}, Readaddress_B, sb);
    chk({tag, " read WE"}, WE, 0);
    @(negedge CLK);
    chk({tag, " exec strobes"}, {RE_A, RE_B, WE, done}, 0);
    @(negedge CLK);
    chk({tag, " write WE/done"}, {WE, done}, 2'b11);
    chk({tag, " write addr"}, Writeaddress, dst);
    chk({tag, " write data"}, wr_data, exp_d);
    @(negedge CLK);
    chk({tag, " flags"}, {flag_z, flag_c}, {exp_z, exp_c});
    chk({tag, " rf commit"}, rf[dst], exp_d);
    ref_rf[dst] = exp_d;
  endtask

  typedef struct {
    logic [2:0] code;
    logic [4:0] dst, sa, sb;
    logic [7:0] imm;
    logic [7:0] exp_d;
    logic       exp_z, exp_c;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, t0;
    logic [9:0] m;
    logic [2:0] rc;
    logic [4:0] rd, ra, rb;
    logic [7:0] ri;

    vecs[0]  = '{OP_LDI, 5'd3,  5'd0, 5'd0, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[1]  = '{OP_LDI, 5'd1,  5'd0, 5'd0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[2]  = '{OP_LDI, 5'd2,  5'd0, 5'd0, 8'h20, 8'h20, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD, 5'd4,  5'd1, 5'd2, 8'h00, 8'h10, 1'b0, 1'b1};
    vecs[4]  = '{OP_SUB, 5'd5,  5'd2, 5'd1, 8'h00, 8'h30, 1'b0, 1'b1};
    vecs[5]  = '{OP_SUB, 5'd6,  5'd1, 5'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{OP_AND, 5'd9,  5'd1, 5'd2, 8'h00, 8'h20, 1'b0, 1'b0};
    vecs[7]  = '{OP_OR,  5'd10, 5'd1, 5'd2, 8'h00, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{OP_XOR, 5'd11, 5'd1, 5'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{OP_MOV, 5'd12, 5'd1, 5'd2, 8'hFF, 8'hF0, 1'b0, 1'b0};
    vecs[10] = '{OP_SHL, 5'd13, 5'd1, 5'd2, 8'h00, 8'hE0, 1'b0, 1'b1};
    vecs[11] = '{OP_LDI, 5'd14, 5'd1, 5'd2, 8'h00, 8'h00, 1'b1, 1'b0};

    for (int i = 0; i < 32; i++) ref_rf[i] = 8'h00;
    tb_clr = 1'b1;
    RST = 1'b1;
    op_valid = 1'b0;
    drive_op(3'd0, 5'd0, 5'd0, 5'd0, 8'd0);
    op_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset op_ready", op_ready, 0);
    chk("reset strobes", {RE_A, RE_B, WE, done}, 0);
    chk("reset flags", {flag_z, flag_c}, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset addrs", {Readaddress_A, Readaddress_B, Writeaddress}, 0);
    tb_clr = 1'b0;
    RST = 1'b0;
    #1 chk("reset release op_ready", op_ready, 1);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].dst, vecs[i].sa, vecs[i].sb,
             vecs[i].imm, vecs[i].exp_d, vecs[i].exp_z, vecs[i].exp_c);

    // Back-to-back dependent op issued during WRITE
    @(negedge CLK);
    drive_op(OP_LDI, 5'd7, 5'd0, 5'd0, 8'h01);
    @(posedge CLK); #1 op_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("b2b first WE", WE, 1);
    chk("b2b first data", wr_data, 8'h01);
    chk("b2b ready in WRITE", op_ready, 1);
    t0 = cyc;
    drive_op(OP_SHL, 5'd7, 5'd7, 5'd0, 8'h00);
    @(posedge CLK); #1 op_valid = 1'b0;
    @(negedge CLK);
    chk("b2b read addr", Readaddress_A, 7);
    chk("b2b read sees commit", rf_dataA, 8'h01);
    repeat (2) @(negedge CLK);
    chk("b2b second done", done, 1);
    chk("b2b second data", wr_data, 8'h02);
    chk("b2b spacing", cyc - t0, 3);
    @(negedge CLK);
    chk("b2b rf", rf[7], 8'h02);
    ref_rf[7] = 8'h02;

    // Reset during WRITE discards the write
    run_op("pre r8", OP_LDI, 5'd8, 5'd0, 5'd0, 8'h55, 8'h55, 1'b0, 1'b0);
    run_op("pre flags", OP_SUB, 5'd15, 5'd2, 5'd1, 8'h00, 8'h30, 1'b0, 1'b1);
    @(negedge CLK);
    drive_op(OP_ADD, 5'd8, 5'd1, 5'd2, 8'h00);
    @(posedge CLK); #1 op_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst-wr WE before", WE, 1);
    w0 = wr_cnt;
    RST = 1'b1;
    #1;
    chk("rst-wr WE/done forced", {WE, done}, 0);
    chk("rst-wr op_ready", op_ready, 0);
    @(negedge CLK);
    chk("rst-wr flags", {flag_z, flag_c}, 0);
    chk("rst-wr r8 kept", rf[8], 8'h55);
    chk("rst-wr no commit", wr_cnt - w0, 0);
    chk("rst-wr outputs", {WE, done, wr_data}, 0);
    RST = 1'b0;
    #1 chk("rst-wr ready after", op_ready, 1);

    // op_valid held through READ/EXEC: second op only taken in WRITE
    @(negedge CLK);
    w0 = wr_cnt;
    drive_op(OP_ADD, 5'd21, 5'd1, 5'd2, 8'h00);
    @(posedge CLK); #1 drive_op(OP_MOV, 5'd20, 5'd3, 5'd0, 8'h00);
    @(negedge CLK);
    chk("hold READ ready", op_ready, 0);
    chk("hold first srcA", Readaddress_A, 1);
    @(negedge CLK);
    chk("hold EXEC ready", op_ready, 0);
    @(negedge CLK);
    chk("hold WRITE first", {Writeaddress, wr_data}, {5'd21, 8'h10});
    chk("hold WRITE ready", op_ready, 1);
    @(posedge CLK); #1 op_valid = 1'b0;
    @(negedge CLK);
    chk("hold second srcA", Readaddress_A, 3);
    repeat (2) @(negedge CLK);
    chk("hold WRITE second", {Writeaddress, wr_data}, {5'd20, 8'h7F});
    @(negedge CLK);
    chk("hold write count", wr_cnt - w0, 2);
    chk("hold rf", {rf[20], rf[21]}, {8'h7F, 8'h10});
    ref_rf[20] = 8'h7F;
    ref_rf[21] = 8'h10;

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rc = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      ri = 8'($urandom_range(0, 255));
      m = model(rc, int'(ref_rf[ra]), int'(ref_rf[rb]), int'(ri));
      run_op($sformatf("rnd%0d", n), rc, rd, ra, rb, ri, m[7:0], m[9], m[8]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
